// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the RV64 ALU: decodes one RV64I integer instruction per
// handshake into registered ALU operands and controls, plus branch and writeback info.
module alu_issue_stage #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [2:0]      func,
    output logic            sub_sra,
    output logic            is_branch,
    output logic [2:0]      branch_cond,
    output logic [4:0]      rd,
    output logic            wb_en,
    output logic            illegal
);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [4:0]      dec_rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;

    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic [2:0]      dec_func;
    logic            dec_sub_sra;
    logic            dec_is_branch;
    logic [2:0]      dec_branch_cond;
    logic            dec_wb_en;
    logic            dec_illegal;
    logic            capture;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign dec_rd = instr[11:7];
    assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_u  = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
    assign shamt  = {{(XLEN-6){1'b0}}, instr[25:20]};

    assign in_ready = !flush && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;

    always_comb begin
        dec_a           = '0;
        dec_b           = '0;
        dec_func        = 3'b000;
        dec_sub_sra     = 1'b0;
        dec_is_branch   = 1'b0;
        dec_branch_cond = 3'b000;
        dec_wb_en       = 1'b0;
        dec_illegal     = 1'b0;
        unique case (opcode)
            OpcOp: begin
                dec_a       = rs1_data;
                dec_b       = rs2_data;
                dec_func    = f3;
                dec_sub_sra = instr[30];
                dec_wb_en   = (dec_rd != 5'd0);
            end
            OpcOpImm: begin
                dec_a       = rs1_data;
                dec_b       = (f3 == 3'b001 || f3 == 3'b101) ? shamt : imm_i;
                dec_func    = f3;
                dec_sub_sra = (f3 == 3'b101) && instr[30];
                dec_wb_en   = (dec_rd != 5'd0);
            end
            OpcLui: begin
                dec_b     = imm_u;
                dec_wb_en = (dec_rd != 5'd0);
            end
            OpcAuipc: begin
                dec_a     = pc;
                dec_b     = imm_u;
                dec_wb_en = (dec_rd != 5'd0);
            end
            OpcBranch: begin
                // The ALU comparator flags are only meaningful in subtract mode.
                dec_a           = rs1_data;
                dec_b           = rs2_data;
                dec_sub_sra     = 1'b1;
                dec_is_branch   = 1'b1;
                dec_branch_cond = f3;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a           <= '0;
            b           <= '0;
            func        <= 3'b000;
            sub_sra     <= 1'b0;
            is_branch   <= 1'b0;
            branch_cond <= 3'b000;
            rd          <= 5'd0;
            wb_en       <= 1'b0;
            illegal     <= 1'b0;
        end else if (capture) begin
            a           <= dec_a;
            b           <= dec_b;
            func        <= dec_func;
            sub_sra     <= dec_sub_sra;
            is_branch   <= dec_is_branch;
            branch_cond <= dec_branch_cond;
            rd          <= dec_rd;
            wb_en       <= dec_wb_en;
            illegal     <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage with hand-computed decode results.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  func;
    logic        sub_sra;
    logic        is_branch;
    logic [2:0]  branch_cond;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b), .func(func),
        .sub_sra(sub_sra), .is_branch(is_branch), .branch_cond(branch_cond), .rd(rd),
        .wb_en(wb_en), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] i, input logic [63:0] p, input logic [63:0] r1,
                         input logic [63:0] r2);
        @(negedge clk);
        instr = i; pc = p; rs1_data = r1; rs2_data = r2;
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_a"}, a, 64'd0);
        check({tag, "_b"}, b, 64'd0);
        check({tag, "_func"}, 64'(func), 64'd0);
        check({tag, "_sub"}, 64'(sub_sra), 64'd0);
        check({tag, "_br"}, 64'(is_branch), 64'd0);
        check({tag, "_cond"}, 64'(branch_cond), 64'd0);
        check({tag, "_rd"}, 64'(rd), 64'd0);
        check({tag, "_wb"}, 64'(wb_en), 64'd0);
        check({tag, "_ill"}, 64'(illegal), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'h0; pc = 64'h0; rs1_data = 64'h0; rs2_data = 64'h0;
        #1;
        check_zero("rst");
        check("rst_in_ready", 64'(in_ready), 64'd1);
        flush = 1'b1;
        #1;
        check("rst_flush_in_ready", 64'(in_ready), 64'd0);
        flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD x3, x1, x2
        issue(32'h002081B3, 64'h1000, 64'd5, 64'd7);
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_a", a, 64'd5);
        check("add_b", b, 64'd7);
        check("add_func", 64'(func), 64'd0);
        check("add_sub", 64'(sub_sra), 64'd0);
        check("add_rd", 64'(rd), 64'd3);
        check("add_wb", 64'(wb_en), 64'd1);
        check("add_br", 64'(is_branch), 64'd0);
        check("add_ill", 64'(illegal), 64'd0);

        // SUB then SRAI back-to-back
        issue(32'h402081B3, 64'h1004, 64'd10, 64'd3);
        check("sub_valid", 64'(out_valid), 64'd1);
        check("sub_sub", 64'(sub_sra), 64'd1);
        check("sub_func", 64'(func), 64'd0);
        check("sub_a", a, 64'd10);
        check("sub_b", b, 64'd3);
        issue(32'h43F0D193, 64'h1008, 64'h8000_0000_0000_0000, 64'd99);
        check("srai_valid", 64'(out_valid), 64'd1);
        check("srai_func", 64'(func), 64'd5);
        check("srai_sub", 64'(sub_sra), 64'd1);
        check("srai_a", a, 64'h8000_0000_0000_0000);
        check("srai_b", b, 64'h3F);

        // ADDI x3, x1, -1: instr[30] set but f3=000 so no sub
        issue(32'hFFF08193, 64'h100C, 64'd1, 64'd2);
        check("addi_b", b, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_sub", 64'(sub_sra), 64'd0);
        check("addi_func", 64'(func), 64'd0);

        issue(32'h800002B7, 64'h1010, 64'h1234, 64'h5678);
        check("lui_a", a, 64'd0);
        check("lui_b", b, 64'hFFFF_FFFF_8000_0000);
        check("lui_rd", 64'(rd), 64'd5);
        check("lui_wb", 64'(wb_en), 64'd1);

        issue(32'h12345297, 64'h0000_0000_0000_2000, 64'h1, 64'h2);
        check("auipc_a", a, 64'h2000);
        check("auipc_b", b, 64'h1234_5000);

        // BEQ and BNE
        issue(32'h00208463, 64'h1018, 64'd11, 64'd22);
        check("beq_br", 64'(is_branch), 64'd1);
        check("beq_cond", 64'(branch_cond), 64'd0);
        check("beq_sub", 64'(sub_sra), 64'd1);
        check("beq_wb", 64'(wb_en), 64'd0);
        check("beq_a", a, 64'd11);
        check("beq_b", b, 64'd22);
        issue(32'h00209463, 64'h101C, 64'd11, 64'd22);
        check("bne_cond", 64'(branch_cond), 64'd1);

        // ADD with rd=x0
        issue(32'h00208033, 64'h1020, 64'd1, 64'd1);
        check("rd0_wb", 64'(wb_en), 64'd0);

        // Stall for 3 cycles with a different instruction offered
        issue(32'h002081B3, 64'h1024, 64'd5, 64'd7);
        @(negedge clk);
        instr = 32'h402081B3; rs1_data = 64'd99; rs2_data = 64'd98; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_a", a, 64'd5);
            check("stall_sub", 64'(sub_sra), 64'd0);
        end

        // Flush while an instruction is offered
        @(negedge clk);
        flush = 1'b1; out_ready = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_a", a, 64'd5);
        check("flush_sub", 64'(sub_sra), 64'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;

        // Consume without capture: valid drops, data holds
        issue(32'h002081B3, 64'h1028, 64'd40, 64'd2);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_a", a, 64'd40);

        // Illegal opcode (ECALL)
        issue(32'h00000073, 64'h102C, 64'd3, 64'd4);
        check("ill_valid", 64'(out_valid), 64'd1);
        check("ill_ill", 64'(illegal), 64'd1);
        check("ill_wb", 64'(wb_en), 64'd0);
        check("ill_a", a, 64'd0);
        check("ill_b", b, 64'd0);

        // Asynchronous reset during a stall
        issue(32'hFFF08193, 64'h1030, 64'd5, 64'd7);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("arst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/issue pipeline stage directly upstream of the ALU in the RV64 core. Decodes one RV64I integer instruction per handshake into the ALU's `a`, `b`, `func` and `sub_sra` controls and registers them with branch and writeback side information. Uses a valid/ready handshake with synchronous flush. The registered outputs connect straight to the ALU inputs.

## Interface
Parameters:
- `XLEN`, 64, datapath width. Only 64 is supported.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `flush`  in  1  synchronous kill of the held and incoming instruction.
- `in_valid`  in  1  upstream offers an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `instr`  in  32  instruction word.
- `pc`  in  64  instruction address.
- `rs1_data`, `rs2_data`  in  64 each  register-file read data.
- `out_valid`  out  1  registered outputs hold a live instruction.
- `out_ready`  in  1  ALU stage consumes this cycle.
- `a`, `b`  out  64 each  ALU operands.
- `func`  out  3  ALU function select.
- `sub_sra`  out  1  ALU subtract / arithmetic-shift select.
- `is_branch`  out  1  instruction is a conditional branch.
- `branch_cond`  out  3  branch funct3, passed through.
- `rd`  out  5  destination register.
- `wb_en`  out  1  result must be written back.
- `illegal`  out  1  opcode is not supported.

## Operation
- Handshake:
  - `in_ready = !flush && (!out_valid || out_ready)`.
  - Capture happens when `in_valid && in_ready`.
- Capture effects: `out_valid <= 1` and all outputs load the decoded values.
- Consume without capture (`out_valid && out_ready` and no capture): `out_valid <= 0`. Data outputs hold their last values.
- Stall (`out_valid && !out_ready`): every output holds. `in_ready` is 0.
- Flush:
  - `out_valid <= 0` next edge, whatever the other inputs are.
  - The instruction offered during the flush cycle is not captured.
- Decode is by opcode `instr[6:0]`. `f3 = instr[14:12]`, `rd = instr[11:7]`.
  - OP (0110011): `a = rs1`, `b = rs2`, `func = f3`, `sub_sra = instr[30]`.
  - OP-IMM (0010011): `a = rs1`, `func = f3`.
    - `b` = sign-extended `instr[31:20]`.
    - Shifts (f3 = 001 or 101): `b = {58'b0, instr[25:20]}` instead.
    - `sub_sra = instr[30]` only when f3 = 101, otherwise 0.
  - LUI (0110111): `a = 0`, `b = sext({instr[31:12], 12'b0})`, `func = 000`, `sub_sra = 0`.
  - AUIPC (0010111): same as LUI but `a = pc`.
  - BRANCH (1100011): `a = rs1`, `b = rs2`, `func = 000`, `sub_sra = 1`.
    - `is_branch = 1` and `branch_cond = f3`.
    - The ALU comparator flags are valid only with `sub_sra = 1`, so this encoding is mandatory.
  - Any other opcode: `illegal = 1`, `a = b = 0`, `func = 000`, `sub_sra = 0`, `wb_en = 0`.
- `wb_en = 1` for OP, OP-IMM, LUI and AUIPC when `rd != 0`; otherwise 0.
- `is_branch = 0` and `branch_cond = 000` for every non-branch opcode.
- Sign extension is always replication of bit 31 of the instruction to bit 63.

## Timing
- Reset values: all outputs 0. This includes `out_valid`, `a`, `b`, `func`, `sub_sra`, `is_branch`, `branch_cond`, `rd`, `wb_en` and `illegal`.
- `in_ready` is combinational. During reset it is 1 unless `flush` is high.
- Latency is 1 cycle: an instruction captured at edge N appears on the outputs after edge N.
- Throughput is 1 instruction per cycle when `out_ready` stays high. Back-to-back captures replace the outputs with no bubble.
- Reset asserted mid-stall clears `out_valid` immediately, without waiting for a clock edge.
- Outputs are driven only from flops. No path goes combinationally from `instr` to the ALU operands.

## Test plan
- ADD: `instr = 0x002081B3`, rs1 = 5, rs2 = 7, `in_valid = 1`, `out_ready = 1`.
  - Next cycle: `a = 5`, `b = 7`, `func = 000`, `sub_sra = 0`, `rd = 3`, `wb_en = 1`, `out_valid = 1`.
- SUB then SRAI back-to-back: `0x402081B3` then `0x43F0D193` (SRAI x3, x1, 63).
  - First output: `sub_sra = 1`, `func = 000`.
  - Second output: `func = 101`, `sub_sra = 1`, `b = 0x3F`.
- ADDI and LUI: `0xFFF08193` (ADDI x3, x1, -1) gives `b = 0xFFFFFFFFFFFFFFFF`.
  - `0x800002B7` (LUI x5) gives `a = 0`, `b = 0xFFFFFFFF80000000`, `rd = 5`.
- BEQ: `0x00208463`.
  - Outputs: `is_branch = 1`, `branch_cond = 000`, `sub_sra = 1`, `wb_en = 0`.
- Stall and flush:
  - Hold `out_ready = 0` for 3 cycles: outputs stable and `in_ready = 0` throughout.
  - Assert `flush` with `in_valid = 1`: `out_valid = 0` next cycle and the new instruction is not captured.
- Reset and illegal opcode:
  - `instr = 0x00000073` gives `illegal = 1`, `wb_en = 0`.
  - Dropping `rst_n` while `out_valid = 1` zeroes every output immediately.
